// File: rtl/digdug_cpu_irq_ctrl.sv
// Purpose : sequences the three Z80 cores. Holds the CPU control latches (IE0, IE1,
//           NMI2_DIS, SUBRUN), times the power-on reset release, the vblank IRQs and the
//           sub-CPU NMI pulses, and registers the I/O chip NMI for the main CPU.
// Ports   : mclk_i/reset_i clock and synchronous active-high reset;
//           wr_en_i/wr_ad_i/wr_d0_i control latch write strobe, index and data bit;
//           line_stb_i/vpos_i video line strobe and line number;
//           ioc_nmi_i NMI request from the I/O chip;
//           rsts_o/irqs_o/nmis_o per-CPU reset, IRQ and NMI ([0]=main [1]=sub [2]=sound).
// Option  : define WATCHDOG_EN to add the vblank watchdog (kick = write to index 4).
module digdug_cpu_irq_ctrl #(
  parameter int unsigned VBL_LINE   = 224,
  parameter int unsigned NMI_LINE_A = 64,
  parameter int unsigned NMI_LINE_B = 192,
  parameter int unsigned NMI_W      = 64,
  parameter int unsigned RST_HOLD   = 256
`ifdef WATCHDOG_EN
  ,
  parameter int unsigned WDOG_FRAMES = 8
`endif
) (
  input  logic       mclk_i,
  input  logic       reset_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_ad_i,
  input  logic       wr_d0_i,
  input  logic       line_stb_i,
  input  logic [8:0] vpos_i,
  input  logic       ioc_nmi_i,
  output logic [2:0] rsts_o,
  output logic [2:0] irqs_o,
  output logic [2:0] nmis_o
);

  localparam logic [8:0]  VBL_V   = 9'(VBL_LINE);
  localparam logic [8:0]  NMIA_V  = 9'(NMI_LINE_A);
  localparam logic [8:0]  NMIB_V  = 9'(NMI_LINE_B);
  localparam logic [7:0]  NMIW_V  = 8'(NMI_W);
  localparam logic [15:0] HOLD_V  = 16'(RST_HOLD);

  logic [15:0] hold_q, hold_d;
  logic        ie0_q, ie0_d;
  logic        ie1_q, ie1_d;
  logic        nmi2_dis_q, nmi2_dis_d;
  logic        subrun_q, subrun_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic [7:0]  nmi2_cnt_q, nmi2_cnt_d;
  logic        nmi0_q;

  logic vbl_stb, nmi_stb;
  logic wr0, wr1, wr2, wr3;
  logic hold_nz, nmi2_nz;

  assign vbl_stb = line_stb_i && (vpos_i == VBL_V);
  assign nmi_stb = line_stb_i && ((vpos_i == NMIA_V) || (vpos_i == NMIB_V));
  assign wr0     = wr_en_i && (wr_ad_i == 3'd0);
  assign wr1     = wr_en_i && (wr_ad_i == 3'd1);
  assign wr2     = wr_en_i && (wr_ad_i == 3'd2);
  assign wr3     = wr_en_i && (wr_ad_i == 3'd3);
  assign hold_nz = (hold_q != 16'd0);
  assign nmi2_nz = (nmi2_cnt_q != 8'd0);

`ifdef WATCHDOG_EN
  localparam logic [3:0] WDOG_V = 4'(WDOG_FRAMES);
  logic [3:0] wdog_q, wdog_d;
  logic       wdog_fire;
  logic       wr4;
  assign wr4 = wr_en_i && (wr_ad_i == 3'd4);
`endif

  always_comb begin
    hold_d     = hold_nz ? hold_q - 16'd1 : hold_q;
    ie0_d      = wr0 ? wr_d0_i : ie0_q;
    ie1_d      = wr1 ? wr_d0_i : ie1_q;
    nmi2_dis_d = wr2 ? wr_d0_i : nmi2_dis_q;
    subrun_d   = wr3 ? wr_d0_i : subrun_q;

    // Writing IEn=0 is the acknowledge; it beats a same-cycle vblank set.
    pend0_d = pend0_q;
    if (wr0 && !wr_d0_i)           pend0_d = 1'b0;
    else if (vbl_stb && ie0_q)     pend0_d = 1'b1;

    pend1_d = pend1_q;
    if (!subrun_q || (wr1 && !wr_d0_i)) pend1_d = 1'b0;
    else if (vbl_stb && ie1_q)          pend1_d = 1'b1;

    // A retrigger reloads the counter, so overlapping pulses merge without a gap.
    nmi2_cnt_d = nmi2_cnt_q;
    if (!subrun_q)                      nmi2_cnt_d = 8'd0;
    else if (nmi_stb && !nmi2_dis_q)    nmi2_cnt_d = NMIW_V;
    else if (nmi2_nz)                   nmi2_cnt_d = nmi2_cnt_q - 8'd1;

`ifdef WATCHDOG_EN
    wdog_d    = wdog_q;
    wdog_fire = 1'b0;
    if (wr4) begin
      wdog_d = 4'd0;
    end else if (vbl_stb) begin
      if ((wdog_q + 4'd1) == WDOG_V) begin
        wdog_d    = 4'd0;
        wdog_fire = 1'b1;
      end else begin
        wdog_d = wdog_q + 4'd1;
      end
    end
    // Self-reset: latches back to power-on values and the reset hold replays.
    if (wdog_fire) begin
      ie0_d      = 1'b0;
      ie1_d      = 1'b0;
      nmi2_dis_d = 1'b1;
      subrun_d   = 1'b0;
      hold_d     = HOLD_V;
    end
`endif
  end

  always_ff @(posedge mclk_i) begin
    if (reset_i) begin
      hold_q     <= HOLD_V;
      ie0_q      <= 1'b0;
      ie1_q      <= 1'b0;
      nmi2_dis_q <= 1'b1;
      subrun_q   <= 1'b0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      nmi2_cnt_q <= 8'd0;
      nmi0_q     <= 1'b0;
`ifdef WATCHDOG_EN
      wdog_q     <= 4'd0;
`endif
    end else begin
      hold_q     <= hold_d;
      ie0_q      <= ie0_d;
      ie1_q      <= ie1_d;
      nmi2_dis_q <= nmi2_dis_d;
      subrun_q   <= subrun_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      nmi2_cnt_q <= nmi2_cnt_d;
      nmi0_q     <= ioc_nmi_i;
`ifdef WATCHDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  // SUBRUN gates the sub/sound outputs directly so that stopping the sub CPUs
  // silences IRQ1 and NMI2 in the same cycle the reset lines rise.
  assign rsts_o = {{2{~subrun_q | hold_nz}}, hold_nz};
  assign irqs_o = {1'b0, pend1_q & subrun_q, pend0_q};
  assign nmis_o = {nmi2_nz & subrun_q, 1'b0, nmi0_q};

endmodule

// File: tb/tb_digdug_cpu_irq_ctrl.sv
module tb_digdug_cpu_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_ad;
  logic       wr_d0;
  logic       line_stb;
  logic [8:0] vpos;
  logic       ioc_nmi;
  logic [2:0] rsts, irqs, nmis;

  digdug_cpu_irq_ctrl dut (
    .mclk_i     (clk),
    .reset_i    (rst),
    .wr_en_i    (wr_en),
    .wr_ad_i    (wr_ad),
    .wr_d0_i    (wr_d0),
    .line_stb_i (line_stb),
    .vpos_i     (vpos),
    .ioc_nmi_i  (ioc_nmi),
    .rsts_o     (rsts),
    .irqs_o     (irqs),
    .nmis_o     (nmis)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    logic [2:0] r;
    logic [2:0] i;
    logic [2:0] n;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: every expectation due at or before this cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({rsts, irqs, nmis} !== {mon_e.r, mon_e.i, mon_e.n}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got rsts=%b irqs=%b nmis=%b, want rsts=%b irqs=%b nmis=%b",
                 mon_e.name, cyc, rsts, irqs, nmis, mon_e.r, mon_e.i, mon_e.n);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int ofs, input logic [2:0] r, input logic [2:0] i,
                           input logic [2:0] n, input string nm);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.r    = r;
    e.i    = i;
    e.n    = n;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] ad, input logic d);
    wr_en = 1'b1;
    wr_ad = ad;
    wr_d0 = d;
    tick(1);
    wr_en = 1'b0;
    wr_d0 = 1'b0;
  endtask

  task automatic strobe(input logic [8:0] v);
    line_stb = 1'b1;
    vpos     = v;
    tick(1);
    line_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ad = 3'd0; wr_d0 = 1'b0;
    line_stb = 1'b0; vpos = 9'd0; ioc_nmi = 1'b0;

    // Reset and power-on hold: 256 cycles of 111 after release, then 110.
    tick(1);
    expect_at(0, 3'b111, 3'b000, 3'b000, "reset_state");
    tick(3);
    rst = 1'b0;
    expect_at(1,   3'b111, 3'b000, 3'b000, "hold_start");
    expect_at(255, 3'b111, 3'b000, 3'b000, "hold_last");
    expect_at(256, 3'b110, 3'b000, 3'b000, "hold_release");
    tick(256);

    // SUBRUN releases sub CPUs; clearing it masks and clears IRQ1.
    wr(3'd3, 1'b1); expect_at(0, 3'b000, 3'b000, 3'b000, "subrun_on");
    wr(3'd1, 1'b1);
    strobe(9'd224); expect_at(0, 3'b000, 3'b010, 3'b000, "irq1_set");
    wr(3'd3, 1'b0); expect_at(0, 3'b110, 3'b000, 3'b000, "subrun_off");
    tick(1);
    wr(3'd3, 1'b1); expect_at(0, 3'b000, 3'b000, 3'b000, "irq1_pend_cleared");

    // IRQ0 set, hold, acknowledge, and clear-wins collision.
    wr(3'd0, 1'b1);
    strobe(9'd223); expect_at(0, 3'b000, 3'b000, 3'b000, "irq_wrong_line");
    strobe(9'd224); expect_at(0, 3'b000, 3'b011, 3'b000, "irq_both_set");
    tick(3);        expect_at(0, 3'b000, 3'b011, 3'b000, "irq_held");
    wr(3'd0, 1'b0); expect_at(0, 3'b000, 3'b010, 3'b000, "irq0_ack");
    wr(3'd0, 1'b1);
    wr_en = 1'b1; wr_ad = 3'd0; wr_d0 = 1'b0; line_stb = 1'b1; vpos = 9'd224;
    tick(1);
    wr_en = 1'b0; line_stb = 1'b0;
    expect_at(0, 3'b000, 3'b010, 3'b000, "irq0_clear_wins");
    tick(1);        expect_at(0, 3'b000, 3'b010, 3'b000, "irq0_stays_clear");
    wr(3'd1, 1'b0); expect_at(0, 3'b000, 3'b000, 3'b000, "irq1_ack");

    // NMI2: disabled by default, 64-cycle pulse, retrigger extends to 104.
    strobe(9'd64);  expect_at(0, 3'b000, 3'b000, 3'b000, "nmi2_disabled");
    wr(3'd2, 1'b0);
    strobe(9'd64);
    expect_at(0,  3'b000, 3'b000, 3'b100, "nmi2_first");
    expect_at(39, 3'b000, 3'b000, 3'b100, "nmi2_before_retrig");
    tick(39);
    strobe(9'd192);
    expect_at(0,  3'b000, 3'b000, 3'b100, "nmi2_retrig");
    expect_at(23, 3'b000, 3'b000, 3'b100, "nmi2_orig_last");
    expect_at(24, 3'b000, 3'b000, 3'b100, "nmi2_no_gap");
    expect_at(63, 3'b000, 3'b000, 3'b100, "nmi2_ext_last");
    expect_at(64, 3'b000, 3'b000, 3'b000, "nmi2_ext_end");
    tick(64);
    wr(3'd2, 1'b1);
    strobe(9'd64);  expect_at(0, 3'b000, 3'b000, 3'b000, "nmi2_redisabled");
    wr(3'd2, 1'b0);
    strobe(9'd192); expect_at(0, 3'b000, 3'b000, 3'b100, "nmi2_line_b");
    wr(3'd3, 1'b0); expect_at(0, 3'b110, 3'b000, 3'b000, "nmi2_subrun_kill");
    wr(3'd3, 1'b1); expect_at(0, 3'b000, 3'b000, 3'b000, "nmi2_cnt_cleared");

    // IOC NMI passes through with one cycle of latency.
    ioc_nmi = 1'b1;
    tick(1); expect_at(0, 3'b000, 3'b000, 3'b001, "ioc_nmi_1");
    tick(1); expect_at(0, 3'b000, 3'b000, 3'b001, "ioc_nmi_2");
    tick(1); expect_at(0, 3'b000, 3'b000, 3'b001, "ioc_nmi_3");
    ioc_nmi = 1'b0;
    tick(1); expect_at(0, 3'b000, 3'b000, 3'b000, "ioc_nmi_end");

    // Reset in the middle of both NMIs.
    strobe(9'd64);  expect_at(0, 3'b000, 3'b000, 3'b100, "pre_reset_nmi2");
    ioc_nmi = 1'b1;
    tick(1);        expect_at(0, 3'b000, 3'b000, 3'b101, "pre_reset_both");
    rst = 1'b1;
    tick(1);        expect_at(0, 3'b111, 3'b000, 3'b000, "mid_reset");
    rst = 1'b0; ioc_nmi = 1'b0;
    tick(1);        expect_at(0, 3'b111, 3'b000, 3'b000, "post_reset_hold");
    expect_at(255, 3'b110, 3'b000, 3'b000, "post_reset_release");
    tick(255);

`ifdef WATCHDOG_EN
    wr(3'd3, 1'b1);
    for (int r = 0; r < 3; r++) begin
      repeat (7) strobe(9'd224);
      wr(3'd4, 1'b1);
      expect_at(0, 3'b000, 3'b000, 3'b000, "wdog_kicked");
    end
    repeat (7) strobe(9'd224);
    expect_at(0, 3'b000, 3'b000, 3'b000, "wdog_seven");
    strobe(9'd224);
    expect_at(0,   3'b111, 3'b000, 3'b000, "wdog_fire");
    expect_at(255, 3'b111, 3'b000, 3'b000, "wdog_hold_last");
    expect_at(256, 3'b110, 3'b000, 3'b000, "wdog_release");
    tick(256);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) tick(1);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
